// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter on the data-memory port.
//            A 4-word register window (TXDATA, STATUS, DIV, FRAMES) feeds
//            a byte FIFO that a serializer drains onto tx.
// Revision : 1.0  initial release
// ============================================================================
module mmio_uart_tx #(
    parameter logic [6:0]  BASE_WORD = 7'h7C,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  rd_addr0,
    output logic [31:0] rd_dout0,
    output logic        rd_hit,
    input  logic [6:0]  wr_addr0,
    input  logic [31:0] wr_din0,
    input  logic        we0,
    input  logic [2:0]  wr_strb,
    output logic        tx
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic [15:0]   div_q;
    logic [15:0]   div_d;

    // Serializer state
    state_t        state_q;
    logic [7:0]    shift_q;
    logic [15:0]   active_div_q;
    logic [15:0]   baud_q;
    logic [2:0]    bit_q;
    logic [15:0]   frames_q;
    logic          tx_q;

    logic          w_wr_hit;
    logic [1:0]    w_wr_off;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic          w_bit_end;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic [7:0]    w_head;
    logic          w_unused_bits;

    assign w_wr_hit   = we0 && (wr_addr0[6:2] == BASE_WORD[6:2]);
    assign w_wr_off   = wr_addr0[1:0];
    assign w_full     = (count_q == CW'(DEPTH));
    assign w_empty    = (count_q == '0);
    assign w_busy     = (state_q != S_IDLE);
    assign w_bit_end  = (baud_q == active_div_q - 16'd1);
    // The serializer only ever pops when data is present, so pop and push on
    // an empty FIFO never coincide.
    assign w_pop      = !w_empty && ((state_q == S_IDLE) ||
                                     ((state_q == S_STOP) && w_bit_end));
    assign w_push_req = w_wr_hit && (w_wr_off == 2'd0);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_head     = mem_q[rptr_q];
    assign tx         = tx_q;
    assign w_unused_bits = &{1'b0, wr_din0[31:16]};

    // Next divisor value: byte stores touch only the low byte; zero maps to one
    always_comb begin
        div_d = div_q;
        if (w_wr_hit && (w_wr_off == 2'd2)) begin
            if (wr_strb == 3'b000) begin
                div_d = {div_q[15:8], wr_din0[7:0]};
            end else begin
                div_d = wr_din0[15:0];
            end
            if (div_d == 16'd0) begin
                div_d = 16'd1;
            end
        end
    end

    // Combinational register read mux, no side effects
    always_comb begin
        rd_dout0 = 32'd0;
        rd_hit   = (rd_addr0[6:2] == BASE_WORD[6:2]);
        if (rd_hit) begin
            case (rd_addr0[1:0])
                2'd1:    rd_dout0 = {17'd0, 7'(count_q), 4'd0,
                                     ovf_q, w_busy, w_empty, w_full};
                2'd2:    rd_dout0 = {16'd0, div_q};
                2'd3:    rd_dout0 = {16'd0, frames_q};
                default: rd_dout0 = 32'd0;
            endcase
        end
    end

    // FIFO data array; contents are don't-care once pointers are reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= wr_din0[7:0];
        end
    end

    // FIFO pointers, occupancy, sticky overflow and divisor register
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= DIV_RESET;
        end else begin
            div_q <= div_d;
            if (w_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (w_pop && !w_push) begin
                count_q <= count_q - 1'b1;
            end
            if (w_push_req && w_full && !w_pop) begin
                ovf_q <= 1'b1;
            end else if (w_wr_hit && (w_wr_off == 2'd1) && wr_din0[3]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Serializer FSM: start bit, 8 data bits LSB first, stop bit, registered tx
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tx_q         <= 1'b1;
            shift_q      <= 8'd0;
            active_div_q <= DIV_RESET;
            baud_q       <= 16'd0;
            bit_q        <= 3'd0;
            frames_q     <= 16'd0;
        end else begin
            if ((state_q == S_IDLE) || w_bit_end) begin
                baud_q <= 16'd0;
            end else begin
                baud_q <= baud_q + 16'd1;
            end
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (w_pop) begin
                        shift_q      <= w_head;
                        active_div_q <= div_q;
                        state_q      <= S_START;
                        tx_q         <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        state_q <= S_DATA;
                        bit_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        frames_q <= frames_q + 16'd1;
                        if (w_pop) begin
                            // Back-to-back frame: no idle gap
                            shift_q      <= w_head;
                            active_div_q <= div_q;
                            state_q      <= S_START;
                            tx_q         <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Brief    : Directed bench for mmio_uart_tx. Stimulus queues expected frames
//            into a scoreboard; a monitor decodes tx and compares each frame.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [6:0] BASE  = 7'h7C;
    localparam int         DEPTH = 8;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  rd_addr0 = 7'd0;
    logic [31:0] rd_dout0;
    logic        rd_hit;
    logic [6:0]  wr_addr0 = 7'd0;
    logic [31:0] wr_din0 = 32'd0;
    logic        we0 = 1'b0;
    logic [2:0]  wr_strb = 3'd0;
    logic        tx;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   mon_en   = 1'b0;
    bit   mon_busy = 1'b0;
    bit   need_start = 1'b0;

    mmio_uart_tx #(
        .BASE_WORD (BASE),
        .DEPTH     (DEPTH),
        .DIV_RESET (16'd868)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr0 (rd_addr0),
        .rd_dout0 (rd_dout0),
        .rd_hit   (rd_hit),
        .wr_addr0 (wr_addr0),
        .wr_din0  (wr_din0),
        .we0      (we0),
        .wr_strb  (wr_strb),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic bus_wr(input logic [6:0] addr, input logic [31:0] d, input logic [2:0] s);
        wr_addr0 = addr;
        wr_din0  = d;
        wr_strb  = s;
        we0      = 1'b1;
        @(posedge clk);
        #1;
        we0 = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] off, input logic [31:0] expv, input string name);
        rd_addr0 = BASE + 7'(off);
        #1;
        chk(name, rd_dout0, expv);
    endtask

    task automatic push_byte(input logic [7:0] b, input int div, input bit b2b);
        sb_q.push_back('{data: b, div: div, b2b: b2b});
        bus_wr(BASE, {24'hFFFFFF, b}, SW);
    endtask

    task automatic wait_frames(input int limit, input string name);
        int i;
        for (i = 0; i < limit; i++) begin
            if (sb_q.size() == 0 && !mon_busy) break;
            @(negedge clk);
        end
        n_checks++;
        if (i >= limit) begin
            n_err++;
            $display("FAIL %s: %0d frames still pending after %0d cycles, required 0",
                     name, sb_q.size() + (mon_busy ? 1 : 0), limit);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: decodes each frame on tx against the scoreboard head
    initial begin : monitor
        exp_t e;
        int   bad;
        int   bit_i;
        logic ebit;
        logic bad_got;
        logic bad_exp;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                need_start = 1'b0;
                continue;
            end
            if (need_start) begin
                need_start = 1'b0;
                n_checks++;
                if (tx !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_gap: got tx=%b after stop bit, expected 0 (next start)", tx);
                end
            end
            if (tx === 1'b0) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_frame: got tx=0 with no frame queued, expected 1");
                    for (int k = 0; k < 2000 && tx !== 1'b1; k++) @(negedge clk);
                end else begin
                    mon_busy = 1'b1;
                    e = sb_q.pop_front();
                    bad = -1;
                    bad_got = 1'b0;
                    bad_exp = 1'b0;
                    for (int s = 0; s < 10 * e.div; s++) begin
                        if (s > 0) @(negedge clk);
                        if (!mon_en) break;
                        bit_i = s / e.div;
                        if (bit_i == 0)      ebit = 1'b0;
                        else if (bit_i == 9) ebit = 1'b1;
                        else                 ebit = e.data[bit_i-1];
                        if (tx !== ebit && bad < 0) begin
                            bad = s;
                            bad_got = tx;
                            bad_exp = ebit;
                        end
                    end
                    if (mon_en) begin
                        n_checks++;
                        if (bad >= 0) begin
                            n_err++;
                            $display("FAIL frame_%02h_div%0d: sample %0d got tx=%b, expected %b",
                                     e.data, e.div, bad, bad_got, bad_exp);
                        end
                        need_start = (sb_q.size() > 0) && sb_q[0].b2b;
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lows;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state
        chk("reset_tx", 32'(tx), 32'd1);
        rd_chk(2'd0, 32'd0, "reset_txdata");
        rd_chk(2'd1, 32'h2, "reset_status");
        rd_chk(2'd2, 32'd868, "reset_div");
        rd_chk(2'd3, 32'd0, "reset_frames");
        chk("hit_in_window", 32'(rd_hit), 32'd1);
        rd_addr0 = 7'h10;
        #1;
        chk("hit_outside", 32'(rd_hit), 32'd0);
        chk("dout_outside", rd_dout0, 32'd0);

        // Single frame 0xA5 at DIV=4, latency and busy timing
        bus_wr(BASE + 7'd2, 32'd4, SW);
        sb_q.push_back('{data: 8'hA5, div: 4, b2b: 1'b0});
        bus_wr(BASE, 32'h000000A5, SW);
        chk("tx_before_pop", 32'(tx), 32'd1);
        rd_chk(2'd1, 32'h100, "status_queued");
        @(posedge clk);
        #1;
        chk("tx_start_latency", 32'(tx), 32'd0);
        rd_chk(2'd1, 32'h6, "status_busy_start");
        repeat (39) @(posedge clk);
        #1;
        rd_chk(2'd1, 32'h6, "status_busy_last");
        @(posedge clk);
        #1;
        rd_chk(2'd1, 32'h2, "status_idle_40");
        wait_frames(50, "wait_a5");
        rd_chk(2'd3, 32'd1, "frames_1");

        // Three back-to-back frames at DIV=2
        bus_wr(BASE + 7'd2, 32'd2, SW);
        push_byte(8'h5A, 2, 1'b0);
        push_byte(8'h81, 2, 1'b1);
        push_byte(8'hFF, 2, 1'b1);
        wait_frames(200, "wait_b2b");
        rd_chk(2'd3, 32'd4, "frames_4");
        rd_chk(2'd1, 32'h2, "status_empty_b2b");

        // DIV change mid-frame applies to the next frame only
        bus_wr(BASE + 7'd2, 32'd4, SW);
        push_byte(8'h3C, 4, 1'b0);
        push_byte(8'hC3, 3, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        bus_wr(BASE + 7'd2, 32'd3, SW);
        rd_chk(2'd2, 32'd3, "div_3");
        wait_frames(300, "wait_divchg");
        rd_chk(2'd3, 32'd6, "frames_6");

        // Divisor write encodings and ignored writes
        bus_wr(BASE + 7'd2, 32'h12345600, SB);
        rd_chk(2'd2, 32'd1, "div_sb_zero_to_1");
        bus_wr(BASE + 7'd2, 32'h9999ABCD, SH);
        rd_chk(2'd2, 32'hABCD, "div_sh");
        bus_wr(BASE + 7'd2, 32'h000000EF, SB);
        rd_chk(2'd2, 32'hABEF, "div_sb_low");
        bus_wr(BASE + 7'd2, 32'd0, SW);
        rd_chk(2'd2, 32'd1, "div_sw_zero_to_1");
        bus_wr(BASE + 7'd3, 32'h1234, SW);
        rd_chk(2'd3, 32'd6, "frames_write_ignored");
        bus_wr(7'h78, 32'h55, SW);
        repeat (30) @(posedge clk);
        #1;
        rd_chk(2'd1, 32'h2, "status_outside_write");

        // Reset during DATA with two bytes queued
        bus_wr(BASE + 7'd2, 32'd4, SW);
        mon_en = 1'b0;
        bus_wr(BASE, 32'h11, SW);
        bus_wr(BASE, 32'h22, SW);
        bus_wr(BASE, 32'h33, SW);
        repeat (8) @(posedge clk);
        #1;
        rd_chk(2'd1, 32'h204, "status_mid_data");
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("tx_after_rst", 32'(tx), 32'd1);
        rd_chk(2'd1, 32'h2, "status_after_rst");
        rd_chk(2'd2, 32'd868, "div_after_rst");
        rd_chk(2'd3, 32'd0, "frames_after_rst");
        rst = 1'b0;
        sb_q.delete();
        mon_en = 1'b1;
        lows = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("no_frames_after_rst", 32'(lows), 32'd0);

        // Overflow with the serializer held busy
        @(posedge clk);
        #1;
        bus_wr(BASE + 7'd2, 32'hFFFF, SW);
        mon_en = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            bus_wr(BASE, 32'(k), SW);
        end
        rd_chk(2'd1, 32'h80D, "status_overflow");
        bus_wr(BASE + 7'd1, 32'h8, SW);
        rd_chk(2'd1, 32'h805, "status_ovf_cleared");
        bus_wr(BASE, 32'h77, SW);
        rd_chk(2'd1, 32'h80D, "status_ovf_again");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_chk(2'd1, 32'h2, "status_final_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
